monishvr_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 26 ++
 rtl/sync_fifo_core.sv | 93 +++++++++
 rtl/monishvr_fifo.sv | 64 ++++++
 tb/tb_monishvr_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing and pad-index constants for the monishvr FIFO tile.
// Pointers carry one extra wrap bit so full and empty can be told apart.
package fifo_pkg;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int PTR_W  = ADDR_W + 1;

    localparam int WR_EN_BIT = 2;
    localparam int RD_EN_BIT = 3;
    localparam int DATA_LSB  = 4;
    localparam int FULL_BIT  = 4;
    localparam int EMPTY_BIT = 5;
    localparam int OVF_BIT   = 6;
    localparam int UNF_BIT   = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'h0F;

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO storage: pointers, memory, registered read port,
// occupancy and sticky overflow/underflow flags.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int ADDR_W = fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              wr_ok;

    assign count = wptr_q - rptr_q;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
    assign rd_ok = rd_en_i & ~empty;
    assign wr_ok = wr_en_i & (~full | rd_ok);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_data_d = rd_data_q;
        ovf_d     = ovf_q | (wr_en_i & full & ~rd_ok);
        unf_d     = unf_q | (rd_en_i & empty);
        if (wr_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rptr_d    = rptr_q + PTR_ONE;
            rd_data_d = mem_q[rptr_q[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Storage contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign count_o     = count;
    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/monishvr_fifo.sv
// Tiny Tapeout tile wrapper: maps pads onto the FIFO core, gates requests
// with ena and drives the occupancy count out of the bidirectional pins.
module monishvr_fifo
    import fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic              wr_req;
    logic              rd_req;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
    logic              unused_pins;

    // The pad named rst_n is a high-true reset on this tile.
    assign wr_req  = ena & ui_in[WR_EN_BIT];
    assign rd_req  = ena & ui_in[RD_EN_BIT];
    assign wr_data = ui_in[DATA_LSB +: DATA_W];

    assign unused_pins = ^{uio_in, ui_in[1:0]};

    sync_fifo_core #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_core (
        .clk        (clk),
        .rst        (rst_n),
        .wr_en_i    (wr_req),
        .rd_en_i    (rd_req),
        .wr_data_i  (wr_data),
        .rd_data_o  (rd_data),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (overflow),
        .underflow_o(underflow)
    );

    always_comb begin
        uo_out                 = '0;
        uo_out[DATA_W-1:0]     = rd_data;
        uo_out[FULL_BIT]       = full;
        uo_out[EMPTY_BIT]      = empty;
        uo_out[OVF_BIT]        = overflow;
        uo_out[UNF_BIT]        = underflow;
    end

    assign uio_out = {{(8 - (ADDR_W + 1)){1'b0}}, count};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_monishvr_fifo.sv
// Bench for the monishvr FIFO tile: directed scenarios then randomized traffic,
// each compared against a queue-based reference of the FIFO rules.
module tb_monishvr_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    bit [3:0] q[$];
    bit [3:0] rd_m = 4'h0;
    bit       ovf_m = 1'b0;
    bit       unf_m = 1'b0;

    monishvr_fifo dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_uo();
        logic [7:0] v;
        v[3:0] = rd_m;
        v[4]   = (q.size() == 8);
        v[5]   = (q.size() == 0);
        v[6]   = ovf_m;
        v[7]   = unf_m;
        return v;
    endfunction

    function automatic logic [7:0] model_uio();
        return {4'h0, 4'(q.size())};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_uo"}, uo_out, model_uo());
        chk({tag, "_cnt"}, uio_out, model_uio());
        chk({tag, "_oe"}, uio_oe, 8'h0F);
    endtask

    task automatic model_reset();
        q.delete();
        rd_m  = 4'h0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    // Called at a falling edge; applies one cycle of inputs and checks at the next falling edge.
    task automatic step(input logic e, input logic w, input logic r, input logic [3:0] d,
                        input string tag);
        bit rd_ok;
        bit wr_ok;
        ena    = e;
        ui_in  = {d, r, w, 2'($urandom_range(0, 3))};
        uio_in = 8'($urandom);
        rd_ok  = e && r && (q.size() > 0);
        wr_ok  = e && w && ((q.size() < 8) || rd_ok);
        if (e && w && q.size() == 8 && !rd_ok) ovf_m = 1'b1;
        if (e && r && q.size() == 0) unf_m = 1'b1;
        if (rd_ok) rd_m = q.pop_front();
        if (wr_ok) q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Asserts reset between edges, checks the immediate effect, then releases on a falling edge.
    task automatic reset_now(input string tag);
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_uo", uo_out, 8'h20);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'h0F);
        @(negedge clk);
        rst_n = 1'b0;

        // Hold write for two edges, then one read
        step(1, 1, 0, 4'd1, "p2_w0");
        step(1, 1, 0, 4'd1, "p2_w1");
        step(1, 0, 0, 4'd0, "p2_idle");
        chk("p2_cnt2", uio_out, 8'h02);
        chk("p2_empty0", {7'h0, uo_out[5]}, 8'h00);
        step(1, 0, 1, 4'd0, "p2_rd");
        chk("p2_rdata", {4'h0, uo_out[3:0]}, 8'h01);
        chk("p2_cnt1", uio_out, 8'h01);

        // Fill, overflow, drain in order
        reset_now("p3_rst");
        for (int i = 1; i <= 8; i++) step(1, 1, 0, 4'(i), "p3_fill");
        chk("p3_full", uo_out & 8'h30, 8'h10);
        chk("p3_cnt8", uio_out, 8'h08);
        step(1, 1, 0, 4'd15, "p3_ovf");
        chk("p3_ovf_flag", uo_out & 8'h40, 8'h40);
        chk("p3_ovf_cnt", uio_out, 8'h08);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 1, 4'd0, "p3_drain");
            chk("p3_order", {4'h0, uo_out[3:0]}, 8'(i));
        end
        chk("p3_empty", uo_out & 8'h30, 8'h20);

        // Read on empty
        step(1, 0, 1, 4'd0, "p4_unf");
        chk("p4_unf_flag", uo_out, 8'hE8);

        // Simultaneous read/write when full, then when empty
        reset_now("p5_rst");
        for (int i = 1; i <= 8; i++) step(1, 1, 0, 4'(i), "p5_fill");
        step(1, 1, 1, 4'd9, "p5_rw_full");
        chk("p5_rw_full_uo", uo_out, 8'h11);
        chk("p5_rw_full_cnt", uio_out, 8'h08);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 4'd0, "p5_drain");
        step(1, 1, 1, 4'd5, "p5_rw_empty");
        chk("p5_rw_empty_cnt", uio_out, 8'h01);
        chk("p5_rw_empty_unf", uo_out & 8'h80, 8'h80);

        // ena low blocks everything; async reset mid-cycle
        reset_now("p6_rst");
        step(1, 1, 0, 4'd3, "p6_w");
        step(0, 1, 0, 4'd4, "p6_blk_w");
        step(0, 0, 1, 4'd0, "p6_blk_r");
        step(0, 1, 1, 4'd6, "p6_blk_rw");
        chk("p6_cnt", uio_out, 8'h01);
        step(1, 1, 0, 4'd7, "p6_w1");
        step(1, 1, 0, 4'd8, "p6_w2");
        chk("p6_cnt3", uio_out, 8'h03);
        reset_now("p6_async");
        chk("p6_async_cnt", uio_out, 8'h00);
        chk("p6_async_uo", uo_out, 8'h20);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_now("rnd_rst");
            end else begin
                step(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                     4'($urandom), "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
